// File: rtl/mm_tile_sequencer_pkg.sv
// Shared types and width helpers for the tiled matrix-multiply sequencer.
package mm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mm_state_t;

  localparam int N_DEFAULT     = 512;
  localparam int LANES_DEFAULT = 32;

  // Column groups per output row: each B/C wide word spans LANES columns.
  function automatic int g_of(input int n, input int lanes);
    return n / lanes;
  endfunction

  function automatic int aw_a(input int n);
    return 2 * $clog2(n);
  endfunction

  function automatic int aw_w(input int n, input int lanes);
    return $clog2(n) + $clog2(n / lanes);
  endfunction

  localparam int AW_A = aw_a(N_DEFAULT);
  localparam int AW_W = aw_w(N_DEFAULT, LANES_DEFAULT);

endpackage

// File: rtl/mm_tile_sequencer_if.sv
// Host handshake plus operand/write-back address bus of the sequencer.
interface mm_tile_sequencer_if
  import mm_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int LANES = LANES_DEFAULT
) ();

  localparam int AW_A_I = aw_a(N);
  localparam int AW_W_I = aw_w(N, LANES);

  logic              start;
  logic              hold;
  logic              busy;
  logic              done;
  logic [AW_A_I-1:0] a_addr;
  logic [AW_W_I-1:0] b_addr;
  logic              mac_en;
  logic              mac_clear;
  logic              c_wr_en;
  logic [AW_W_I-1:0] c_addr;

  modport master (
    output start, hold,
    input  busy, done, a_addr, b_addr, mac_en, mac_clear, c_wr_en, c_addr
  );

  modport slave (
    input  start, hold,
    output busy, done, a_addr, b_addr, mac_en, mac_clear, c_wr_en, c_addr
  );

endinterface

// File: rtl/mm_tile_sequencer_wb_delay.sv
// Fixed-latency shift register aligning C write-back strobes with the MAC pipeline.
module mm_wb_delay #(
  parameter int LAT = 3,
  parameter int AW  = 4
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr
);

  logic          valid_q [LAT];
  logic [AW-1:0] addr_q  [LAT];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < LAT; i++) begin
        valid_q[i] <= 1'b0;
        addr_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      addr_q[0]  <= in_addr;
      for (int i = 1; i < LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_addr  = addr_q[LAT-1];

endmodule

// File: rtl/mm_tile_sequencer.sv
// Walks r / g / k for an N x N multiply and emits one operand address pair per cycle
// to a LANES-wide MAC array, with C write-back strobes delayed to match the pipeline.
module mm_tile_sequencer
  import mm_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int LANES = LANES_DEFAULT,
  parameter int LAT   = 3
) (
  input logic             clk,
  input logic             reset,
  mm_tile_sequencer_if.slave bus
);

  localparam int G    = g_of(N, LANES);
  localparam int KW   = $clog2(N);
  localparam int GW   = $clog2(G);
  localparam int AWA  = aw_a(N);
  localparam int AWW  = aw_w(N, LANES);
  localparam int DW   = $clog2(LAT + 1);

  mm_state_t         state, state_next;
  logic [KW-1:0]     r, k;
  logic [GW-1:0]     g;
  logic [DW-1:0]     drain_cnt;
  logic [AWA-1:0]    a_last;
  logic [AWW-1:0]    b_last;
  logic              issue, last_k, last_g, last_r, final_issue;
  logic              wb_valid;
  logic [AWW-1:0]    wb_addr;

  assign issue       = (state == RUN) && !bus.hold;
  assign last_k      = (k == KW'(N - 1));
  assign last_g      = (g == GW'(G - 1));
  assign last_r      = (r == KW'(N - 1));
  assign final_issue = issue && last_k && last_g && last_r;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (final_issue) state_next = DRAIN;
      DRAIN:   if (drain_cnt == DW'(LAT - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // N and G are powers of two, so k and g wrap to zero by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      r         <= '0;
      g         <= '0;
      k         <= '0;
      drain_cnt <= '0;
      a_last    <= '0;
      b_last    <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (state == IDLE) begin
        r      <= '0;
        g      <= '0;
        k      <= '0;
        a_last <= '0;
        b_last <= '0;
      end else if (issue) begin
        a_last <= {r, k};
        b_last <= {k, g};
        k      <= k + 1'b1;
        if (last_k) begin
          g <= g + 1'b1;
          if (last_g) r <= r + 1'b1;
        end
      end
    end
  end

  mm_wb_delay #(
    .LAT (LAT),
    .AW  (AWW)
  ) u_wb_delay (
    .clk       (clk),
    .clear     (reset),
    .in_valid  (issue && last_k),
    .in_addr   ({r, g}),
    .out_valid (wb_valid),
    .out_addr  (wb_addr)
  );

  // During a hold the address lines keep showing the most recently issued pair.
  assign bus.a_addr    = (state == IDLE) ? '0 : (issue ? {r, k} : a_last);
  assign bus.b_addr    = (state == IDLE) ? '0 : (issue ? {k, g} : b_last);
  assign bus.mac_en    = issue;
  assign bus.mac_clear = issue && (k == '0);
  assign bus.busy      = (state == RUN) || (state == DRAIN);
  assign bus.done      = (state == DONE);
  assign bus.c_wr_en   = wb_valid;
  assign bus.c_addr    = wb_valid ? wb_addr : '0;

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// Randomized directed-step bench for mm_tile_sequencer with a schedule-level reference model.
module tb_mm_tile_sequencer;

  localparam int N     = 8;
  localparam int LANES = 4;
  localparam int LAT   = 3;
  localparam int G     = N / LANES;
  localparam int TOTAL = N * N * G;

  localparam int P_IDLE  = 0;
  localparam int P_RUN   = 1;
  localparam int P_DRAIN = 2;
  localparam int P_DONE  = 3;

  typedef struct {
    int cyc;
    int addr;
  } wb_t;

  logic clk;
  logic reset;

  mm_tile_sequencer_if #(.N(N), .LANES(LANES)) bus ();

  mm_tile_sequencer #(
    .N     (N),
    .LANES (LANES),
    .LAT   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int  checks = 0;
  int  passes = 0;
  int  cyc    = 0;

  int  phase = P_IDLE;
  int  issues;
  int  drain_end;
  int  last_a, last_b;
  wb_t wbq[$];

  logic exp_busy, exp_done, exp_mac_en, exp_clear, exp_wr;
  int   exp_a, exp_b, exp_caddr;
  bit   chk_addr;

  int  wr_cnt, mac_cnt, first_wr, done_cyc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // Expected outputs for the current cycle, derived from the issue index alone.
  task automatic model_step(input logic h);
    int i, r, g, k;
    exp_busy = 0; exp_done = 0; exp_mac_en = 0; exp_clear = 0;
    exp_a = 0; exp_b = 0; chk_addr = 1;
    exp_wr = 0; exp_caddr = 0;
    case (phase)
      P_RUN: begin
        exp_busy = 1;
        if (!h) begin
          i = issues;
          k = i % N;
          g = (i / N) % G;
          r = i / (N * G);
          exp_a = r * N + k;
          exp_b = k * G + g;
          exp_mac_en = 1;
          exp_clear = (k == 0);
          last_a = exp_a;
          last_b = exp_b;
          if (k == N - 1) wbq.push_back('{cyc: cyc + LAT, addr: r * G + g});
          issues++;
          if (issues == TOTAL) drain_end = cyc + LAT;
        end else begin
          exp_a = last_a;
          exp_b = last_b;
        end
      end
      P_DRAIN: begin
        exp_busy = 1;
        chk_addr = 0;
      end
      P_DONE: begin
        exp_done = 1;
        chk_addr = 0;
      end
      default: ;
    endcase
    if (wbq.size() > 0 && wbq[0].cyc == cyc) begin
      exp_wr = 1;
      exp_caddr = wbq[0].addr;
      void'(wbq.pop_front());
    end
  endtask

  task automatic model_advance(input logic s, input logic rst);
    if (rst) begin
      phase = P_IDLE;
      wbq.delete();
      return;
    end
    case (phase)
      P_IDLE:  if (s) begin phase = P_RUN; issues = 0; last_a = 0; last_b = 0; end
      P_RUN:   if (issues == TOTAL) phase = P_DRAIN;
      P_DRAIN: if (cyc == drain_end) phase = P_DONE;
      default: phase = P_IDLE;
    endcase
  endtask

  task automatic checkOutput();
    check_val("busy", bus.busy, exp_busy);
    check_val("done", bus.done, exp_done);
    check_val("mac_en", bus.mac_en, exp_mac_en);
    check_val("mac_clear", bus.mac_clear, exp_clear);
    check_val("c_wr_en", bus.c_wr_en, exp_wr);
    check_val("c_addr", bus.c_addr, exp_caddr);
    if (chk_addr) begin
      check_val("a_addr", bus.a_addr, exp_a);
      check_val("b_addr", bus.b_addr, exp_b);
    end
    if (bus.c_wr_en === 1'b1) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
    end
    if (bus.mac_en === 1'b1) mac_cnt++;
    if (bus.done === 1'b1) done_cyc = cyc;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic rst);
    @(posedge clk);
    #1;
    cyc++;
    bus.start = s;
    bus.hold  = h;
    reset     = rst;
    model_step(h);
    @(negedge clk);
    checkOutput();
    model_advance(s, rst);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // One job: start sampled at the end of relative cycle 0, then directed/random holds.
  task automatic run_job(input int hold_lo, input int hold_hi, input bit rand_hold,
                         input bit extra_starts, input int reset_rel, input int exp_first_wr);
    int   jstart, holds, rel;
    logic h, s;
    wr_cnt = 0; mac_cnt = 0; first_wr = -1; done_cyc = -1; holds = 0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    jstart = cyc;
    for (rel = 1; rel < 600 && done_cyc < 0; rel++) begin
      h = (rel >= hold_lo && rel <= hold_hi) || (rand_hold && $urandom_range(0, 7) == 0);
      s = extra_starts && (rel == 50 || rel == 132);
      if (phase == P_RUN && h) holds++;
      applyStimulus(s, h, 1'(rel == reset_rel));
      if (rel == reset_rel) break;
    end
    if (reset_rel > 0) begin
      check_val("wr_before_reset", wr_cnt, 15);
    end else begin
      check_val("job_done_seen", done_cyc >= 0, 1'b1);
      check_val("done_rel_cycle", done_cyc - jstart, TOTAL + LAT + 1 + holds);
      check_val("c_wr_count", wr_cnt, N * G);
      check_val("mac_en_count", mac_cnt, TOTAL);
      if (exp_first_wr > 0) check_val("first_wr_rel", first_wr - jstart, exp_first_wr);
    end
  endtask

  initial begin
    reset    = 1'b1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    idle_cycles(2);

    $display("[TB] basic job");
    run_job(0, -1, 1'b0, 1'b0, 0, 11);
    idle_cycles(5);

    $display("[TB] hold in cycles 5-7");
    run_job(5, 7, 1'b0, 1'b0, 0, 14);
    idle_cycles(3);

    $display("[TB] start pulses while busy and in DONE");
    run_job(0, -1, 1'b0, 1'b1, 0, 11);
    idle_cycles(7);

    $display("[TB] job launched from IDLE with random hold");
    run_job(0, -1, 1'b1, 1'b0, 0, 0);
    idle_cycles(4);

    $display("[TB] reset during drain");
    run_job(0, -1, 1'b0, 1'b0, 129, 0);
    wr_cnt = 0;
    idle_cycles(10);
    check_val("wr_after_reset", wr_cnt, 0);

    $display("[TB] basic job after reset");
    run_job(0, -1, 1'b0, 1'b0, 0, 11);
    idle_cycles(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mm_tile_sequencer.md
# mm_tile_sequencer

Top-level sequencer for the N×N matrix multiplier. It walks output row r, column group g and reduction index k, and drives the A/B read addresses and MAC-lane controls. A fixed-latency delay line produces C write-back strobes aligned to the MAC pipeline. It sits between the host start/done handshake and the LANES-wide MAC array, and replaces free-running per-lane address counters with one scheduled address stream.

## Interface
Parameters:
- N, 512: matrix dimension; power of 2, N ≥ 4.
- LANES, 32: parallel MAC lanes; power of 2, LANES < N.
- LAT, 3: cycles from address issue to accumulated result valid in the lanes; LAT ≥ 1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; returns block to IDLE next edge.
- start  in  1  request; sampled only in IDLE.
- hold  in  1  stall issue (memory not ready); sampled in RUN.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job end.
- a_addr  out  log2(N*N)  scalar A element address = r*N + k.
- b_addr  out  log2(N*N/LANES)  B wide-word address = k*G + g, G = N/LANES.
- mac_en  out  1  issue valid; lanes accumulate this operand pair.
- mac_clear  out  1  with mac_en on k = 0; lanes load instead of add.
- c_wr_en  out  1  write current lane accumulators to C.
- c_addr  out  log2(N*N/LANES)  C wide-word address = r*G + g.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: all outputs 0, and r, g, k = 0. When start = 1, go to RUN.
- RUN, hold = 0: issue one operand pair per cycle (mac_en = 1, addresses as above). Then advance the counters:
  - k increments each issue.
  - When k = N-1: k → 0 and g increments.
  - When g = G-1: g → 0 and r increments.
  - Issuing r = N-1, g = G-1, k = N-1 (the final issue) moves the block to DRAIN.
- RUN, hold = 1: mac_en = 0, counters frozen. a_addr/b_addr hold their last values. The delay line keeps advancing.
- Delay line (LAT stages) carries {valid = mac_en & (k = N-1), c_addr = r*G + g}. Its output drives c_wr_en/c_addr, so c_wr_en rises exactly LAT cycles after each k = N-1 issue, gaps included.
- DRAIN: count LAT cycles, then go to DONE. The final c_wr_en occurs in the last DRAIN cycle.
- DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- start while busy or in DONE is ignored. No queuing.
- hold outside RUN is ignored.
- Reset in any state, including mid-DRAIN:
  - The next edge returns the block to IDLE and clears the counters and all delay stages.
  - No c_wr_en is issued after reset.
- Arithmetic: addresses are concatenations ({r,k}, {k,g}, {r,g}), not multipliers, and cannot overflow.

## Timing
- Reset values: busy = done = mac_en = mac_clear = c_wr_en = 0; a_addr = b_addr = c_addr = 0.
- start sampled high at edge t means first issue (a_addr = 0, b_addr = 0, mac_clear = 1) is visible in cycle t+1. busy = 1 from t+1.
- With no hold, issues occupy N·N·G consecutive cycles.
- The last c_wr_en is at cycle N·N·G + LAT. done is the next cycle, and busy falls in that same cycle.
- Each hold cycle extends every subsequent event by one cycle.
- Throughput is 1 issue per cycle. There is no bubble at k/g/r wrap.

## Structure
- Shared package mm_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - localparam width helpers (AW_A, AW_W, derived from N and LANES);
  - the G derivation.
- Sub-module mm_wb_delay: a LAT-stage shift register of {valid, c_addr} with synchronous clear.
- All other logic lives in the top module: the FSM, the r/g/k counters and the drain counter.

## Test plan
All scenarios use N = 8, LANES = 4, LAT = 3 (G = 2) unless noted.
- Basic job: start pulse at edge 0.
  - Cycle 1: a_addr = 0, b_addr = 0, mac_clear = 1.
  - Cycle 2: a_addr = 1, b_addr = 2.
  - Cycle 9: a_addr = 0, b_addr = 1, mac_clear = 1.
  - Cycle 11: c_wr_en = 1, c_addr = 0.
  - Cycle 131: last c_wr_en, c_addr = 15.
  - Cycle 132: done = 1.
- Write-back count: full job → exactly 16 c_wr_en pulses, c_addr 0…15 in order, mac_en high for exactly 128 cycles.
- Hold: hold = 1 for cycles 5–7.
  - Counters freeze and mac_en = 0 in those cycles.
  - First c_wr_en moves to cycle 14.
  - done moves to cycle 135.
- start ignored: pulse start in cycles 50 and 132 → no effect on the sequence and no second job. A start in cycle 140 (IDLE) launches a new job.
- Reset mid-operation: reset = 1 at cycle 129 (DRAIN).
  - From cycle 130, all outputs are 0, busy = 0 and no c_wr_en appears.
  - A new start produces the basic-job sequence again.
- Default parameters (N = 512, LANES = 32): done exactly 4,194,304 + 3 + 1 cycles after start.
